// File: rtl/dump_ctrl_if.sv
// -----------------------------------------------------------------------------
// dump_ctrl_if
// Bundles every non-clock signal around the channel dump sequencer.
//   master : the sequencer (dump_ctrl) side
//   slave  : the environment side (Command_Config, EEPROM requester,
//            capture RAMs, UART response path)
// Signals:
//   dump, dump_ch          dump start pulse and channel (00/01/10, 11 reserved)
//   ch1..ch3_AFEgain       current AFE gain per channel
//   trace_end              address of the newest captured sample
//   eep_req/eep_addr       EEPROM read request and address
//   eep_done               EEPROM read complete
//   flopOffset/flopGain    capture strobes for offset / gain
//   ram_en/ram_addr/ram_sel capture RAM read strobe, address, one-hot select
//   send_resp/resp_sent    UART transmit strobe and completion
//   busy, dump_done, dump_err status
// -----------------------------------------------------------------------------
interface dump_ctrl_if #(
   parameter int ADDR_W = 9
);
   logic              dump;
   logic [1:0]        dump_ch;
   logic [2:0]        ch1_AFEgain;
   logic [2:0]        ch2_AFEgain;
   logic [2:0]        ch3_AFEgain;
   logic [ADDR_W-1:0] trace_end;
   logic              eep_req;
   logic [5:0]        eep_addr;
   logic              eep_done;
   logic              flopOffset;
   logic              flopGain;
   logic              ram_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [2:0]        ram_sel;
   logic              send_resp;
   logic              resp_sent;
   logic              busy;
   logic              dump_done;
   logic              dump_err;

   modport master (
      input  dump, dump_ch, ch1_AFEgain, ch2_AFEgain, ch3_AFEgain, trace_end,
             eep_done, resp_sent,
      output eep_req, eep_addr, flopOffset, flopGain, ram_en, ram_addr, ram_sel,
             send_resp, busy, dump_done, dump_err
   );

   modport slave (
      output dump, dump_ch, ch1_AFEgain, ch2_AFEgain, ch3_AFEgain, trace_end,
             eep_done, resp_sent,
      input  eep_req, eep_addr, flopOffset, flopGain, ram_en, ram_addr, ram_sel,
             send_resp, busy, dump_done, dump_err
   );
endinterface

// File: rtl/dump_ctrl.sv
// -----------------------------------------------------------------------------
// dump_ctrl
// Sequences one channel dump to the UART: reads the channel's calibration
// offset and gain from the EEPROM (address {ch, AFE gain, sel}), strobes
// them into the gain corrector, then walks the circular capture RAM from the
// oldest sample to the newest, one RAM read + one UART send per sample.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset (aborts any dump in progress)
//   bus    dump_ctrl_if.master, all handshake / data signals
// -----------------------------------------------------------------------------
module dump_ctrl #(
   parameter int ENTRIES = 384,
   parameter int ADDR_W  = 9
) (
   input  logic        clk,
   input  logic        rst_n,
   dump_ctrl_if.master bus
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);

   typedef enum logic [3:0] {
      IDLE, REQ_OFF, WT_OFF, REQ_GAIN, WT_GAIN, RD_RAM, SEND, WT_SENT, DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic [5:0]        r_eep_addr;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_cnt;
   logic [2:0]        r_ram_sel;
   logic              r_dump_err;

   logic              w_reserved;
   logic              w_start;
   logic [2:0]        w_gain;
   logic [2:0]        w_onehot;
   logic [ADDR_W-1:0] w_ptr_start;
   logic [ADDR_W-1:0] w_ptr_inc;

   logic              w_eep_req;
   logic              w_flop_off;
   logic              w_flop_gain;
   logic              w_ram_en;
   logic              w_send;
   logic              w_done;

   // one-hot RAM select decoded from the requested channel
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sel
         assign w_onehot[gi] = (bus.dump_ch == 2'(gi));
      end
   endgenerate

   always_comb begin
      w_gain = 3'b000;
      case (bus.dump_ch)
         2'b00:   w_gain = bus.ch1_AFEgain;
         2'b01:   w_gain = bus.ch2_AFEgain;
         2'b10:   w_gain = bus.ch3_AFEgain;
         default: w_gain = 3'b000;
      endcase
   end

   assign w_reserved = (bus.dump_ch == 2'b11);
   assign w_start    = (r_state == IDLE) && bus.dump && !w_reserved;

   // oldest sample sits just after the newest one in the circular buffer
   assign w_ptr_start = (bus.trace_end == LAST) ? '0 : bus.trace_end + ADDR_W'(1);
   assign w_ptr_inc   = (r_ptr == LAST) ? '0 : r_ptr + ADDR_W'(1);

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // next state and strobes; eep_done-driven flop strobes are Mealy
   always_comb begin
      w_state_next = r_state;
      w_eep_req    = 1'b0;
      w_flop_off   = 1'b0;
      w_flop_gain  = 1'b0;
      w_ram_en     = 1'b0;
      w_send       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start) w_state_next = REQ_OFF;
         end
         REQ_OFF: begin
            w_eep_req    = 1'b1;
            w_state_next = WT_OFF;
         end
         WT_OFF: begin
            if (bus.eep_done) begin
               w_flop_off   = 1'b1;
               w_state_next = REQ_GAIN;
            end
         end
         REQ_GAIN: begin
            w_eep_req    = 1'b1;
            w_state_next = WT_GAIN;
         end
         WT_GAIN: begin
            if (bus.eep_done) begin
               w_flop_gain  = 1'b1;
               w_state_next = RD_RAM;
            end
         end
         RD_RAM: begin
            w_ram_en     = 1'b1;
            w_state_next = SEND;
         end
         SEND: begin
            w_send       = 1'b1;
            w_state_next = WT_SENT;
         end
         WT_SENT: begin
            if (bus.resp_sent) w_state_next = (r_cnt == LAST) ? DONE : RD_RAM;
         end
         DONE: begin
            w_done       = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // datapath: EEPROM address, sample pointer/count, RAM select, error pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_eep_addr <= '0;
         r_ptr      <= '0;
         r_cnt      <= '0;
         r_ram_sel  <= '0;
         r_dump_err <= 1'b0;
      end else begin
         r_dump_err <= (r_state == IDLE) && bus.dump && w_reserved;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_eep_addr <= {bus.dump_ch, w_gain, 1'b0};
                  r_ptr      <= w_ptr_start;
                  r_cnt      <= '0;
                  r_ram_sel  <= w_onehot;
               end
            end
            // switch to the gain word only once the offset read has completed
            WT_OFF: begin
               if (bus.eep_done) r_eep_addr[0] <= 1'b1;
            end
            WT_SENT: begin
               if (bus.resp_sent && (r_cnt != LAST)) begin
                  r_cnt <= r_cnt + ADDR_W'(1);
                  r_ptr <= w_ptr_inc;
               end
            end
            DONE: begin
               r_ram_sel <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.eep_req    = w_eep_req;
   assign bus.eep_addr   = r_eep_addr;
   assign bus.flopOffset = w_flop_off;
   assign bus.flopGain   = w_flop_gain;
   assign bus.ram_en     = w_ram_en;
   assign bus.ram_addr   = r_ptr;
   assign bus.ram_sel    = r_ram_sel;
   assign bus.send_resp  = w_send;
   assign bus.busy       = (r_state != IDLE);
   assign bus.dump_done  = w_done;
   assign bus.dump_err   = r_dump_err;
endmodule

// File: tb/tb_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dump_ctrl
// Self-checking bench for dump_ctrl. A single environment process samples
// the DUT on the falling edge, records every transaction, and answers
// EEPROM and UART handshakes with random latency. Expected behaviour of a
// dump is derived from (channel, gain, trace_end) with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_dump_ctrl;
   localparam int ENTRIES = 384;
   localparam int ADDR_W  = 9;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dump_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   dump_ctrl #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // environment controls
   bit dump_req  = 1'b0;
   int hold_idx  = -1;
   int hold_len  = 0;
   int stray_idx = -1;
   int exp_sel   = 0;

   // recorded activity
   int q_eep[$];
   int q_flop[$];
   int q_flop_addr[$];
   int q_addr[$];
   int send_cnt, done_cnt, done_sends, err_cnt, eep_cnt, ram_cnt, busy_cnt;
   int seq_err, stab_err, sel_err;
   bit awaiting, ram_since_send, have_addr;
   int last_addr;

   task automatic clear_stats();
      q_eep.delete(); q_flop.delete(); q_flop_addr.delete(); q_addr.delete();
      send_cnt = 0; done_cnt = 0; done_sends = 0; err_cnt = 0; eep_cnt = 0;
      ram_cnt = 0; busy_cnt = 0; seq_err = 0; stab_err = 0; sel_err = 0;
      awaiting = 0; ram_since_send = 0; have_addr = 0; last_addr = -1;
   endtask

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   // environment: monitor on negedge, drive on posedge+1
   initial begin
      int eep_cd, resp_cd, stray_cd;
      eep_cd = 0; resp_cd = 0; stray_cd = 0;
      bus.dump = 1'b0; bus.eep_done = 1'b0; bus.resp_sent = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            eep_cd = 0; resp_cd = 0; stray_cd = 0; awaiting = 0; ram_since_send = 0;
         end else begin
            if (bus.eep_req) begin
               eep_cnt++;
               q_eep.push_back(int'(bus.eep_addr));
               eep_cd = $urandom_range(1, 4);
            end
            if (bus.flopOffset || bus.flopGain) begin
               q_flop.push_back({30'd0, bus.flopGain, bus.flopOffset});
               q_flop_addr.push_back(int'(bus.eep_addr));
               if (!bus.eep_done) seq_err++;
            end
            if (bus.ram_en) begin
               ram_cnt++;
               q_addr.push_back(int'(bus.ram_addr));
               if (awaiting || ram_since_send) seq_err++;
               ram_since_send = 1; have_addr = 1; last_addr = int'(bus.ram_addr);
            end else if (bus.busy && have_addr && int'(bus.ram_addr) != last_addr) begin
               stab_err++;
            end
            if (bus.busy && int'(bus.ram_sel) != exp_sel) sel_err++;
            if (bus.send_resp) begin
               if (!ram_since_send || awaiting) seq_err++;
               ram_since_send = 0; awaiting = 1;
               if (send_cnt == hold_idx)       resp_cd = hold_len;
               else if (send_cnt == stray_idx) resp_cd = 6;
               else                            resp_cd = $urandom_range(1, 3);
               stray_cd = (send_cnt == stray_idx) ? 3 : 0;
               send_cnt++;
            end
            if (bus.resp_sent) awaiting = 0;
            if (bus.dump_done) begin done_cnt++; done_sends = send_cnt; end
            if (bus.dump_err) err_cnt++;
            if (bus.busy) busy_cnt++;
         end
         @(posedge clk);
         #1;
         bus.dump = dump_req; dump_req = 1'b0;
         bus.eep_done = 1'b0; bus.resp_sent = 1'b0;
         if (eep_cd > 0) begin eep_cd--; if (eep_cd == 0) bus.eep_done = 1'b1; end
         if (resp_cd > 0) begin resp_cd--; if (resp_cd == 0) bus.resp_sent = 1'b1; end
         if (stray_cd > 0) begin
            stray_cd--;
            if (stray_cd == 0) begin bus.dump = 1'b1; bus.eep_done = 1'b1; end
         end
      end
   end

   task automatic start_dump(input int ch, input int g, input int te);
      @(posedge clk); #2;
      bus.ch1_AFEgain = 3'($urandom_range(0, 7));
      bus.ch2_AFEgain = 3'($urandom_range(0, 7));
      bus.ch3_AFEgain = 3'($urandom_range(0, 7));
      if (ch == 0) bus.ch1_AFEgain = 3'(g);
      if (ch == 1) bus.ch2_AFEgain = 3'(g);
      if (ch == 2) bus.ch3_AFEgain = 3'(g);
      bus.dump_ch   = 2'(ch);
      bus.trace_end = ADDR_W'(te);
      exp_sel = (ch < 3) ? (1 << ch) : 0;
      clear_stats();
      dump_req = 1'b1;
   endtask

   task automatic wait_done();
      for (int c = 0; c < 40000 && done_cnt == 0; c++) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic verify_dump(input string nm, input int ch, input int g, input int te);
      int exp_off, mism, maxa;
      exp_off = (ch << 4) | (g << 1);
      mism = 0; maxa = 0;
      for (int k = 0; k < q_addr.size(); k++) begin
         if (q_addr[k] != (te + 1 + k) % ENTRIES) mism++;
         if (q_addr[k] > maxa) maxa = q_addr[k];
      end
      check_eq({nm, "_eep_reqs"},   q_eep.size(), 2);
      check_eq({nm, "_eep_off"},    qget(q_eep, 0), exp_off);
      check_eq({nm, "_eep_gain"},   qget(q_eep, 1), exp_off | 1);
      check_eq({nm, "_flops"},      q_flop.size(), 2);
      check_eq({nm, "_flop0_off"},  qget(q_flop, 0), 1);
      check_eq({nm, "_flop1_gain"}, qget(q_flop, 1), 2);
      check_eq({nm, "_flop0_addr"}, qget(q_flop_addr, 0), exp_off);
      check_eq({nm, "_flop1_addr"}, qget(q_flop_addr, 1), exp_off | 1);
      check_eq({nm, "_ram_reads"},  q_addr.size(), ENTRIES);
      check_eq({nm, "_first_addr"}, qget(q_addr, 0), (te + 1) % ENTRIES);
      check_eq({nm, "_last_addr"},  qget(q_addr, ENTRIES - 1), te);
      check_eq({nm, "_addr_mism"},  mism, 0);
      check_eq({nm, "_addr_range"}, int'(maxa < ENTRIES), 1);
      check_eq({nm, "_sends"},      send_cnt, ENTRIES);
      check_eq({nm, "_dones"},      done_cnt, 1);
      check_eq({nm, "_done_after"}, done_sends, ENTRIES);
      check_eq({nm, "_seq_err"},    seq_err, 0);
      check_eq({nm, "_stab_err"},   stab_err, 0);
      check_eq({nm, "_sel_err"},    sel_err, 0);
      check_eq({nm, "_errs"},       err_cnt, 0);
      check_eq({nm, "_busy_end"},   int'(bus.busy), 0);
      $display("[TB] dump %s ch=%0d g=%0d te=%0d reads=%0d sends=%0d dones=%0d",
               nm, ch, g, te, q_addr.size(), send_cnt, done_cnt);
   endtask

   initial begin
      int ch, g, te;
      bus.dump_ch = 2'b00; bus.trace_end = '0;
      bus.ch1_AFEgain = 3'd0; bus.ch2_AFEgain = 3'd0; bus.ch3_AFEgain = 3'd0;
      clear_stats();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_busy",     int'(bus.busy), 0);
      check_eq("rst_ram_sel",  int'(bus.ram_sel), 0);
      check_eq("rst_ram_addr", int'(bus.ram_addr), 0);
      check_eq("rst_eep_addr", int'(bus.eep_addr), 0);
      check_eq("rst_strobes",  int'({bus.eep_req, bus.ram_en, bus.send_resp,
                                     bus.dump_done, bus.dump_err}), 0);
      $display("[TB] reset state checked");
      @(posedge clk); #2 rst_n = 1'b1;

      // full dump with back-pressure on sample 5
      hold_idx = 5; hold_len = 101; stray_idx = -1;
      start_dump(1, 5, 10);
      wait_done();
      verify_dump("full", 1, 5, 10);

      // wrap case with stray dump/eep_done during WT_SENT
      hold_idx = -1; stray_idx = 20;
      g = $urandom_range(0, 7);
      start_dump(2, g, ENTRIES - 1);
      wait_done();
      verify_dump("wrap_stray", 2, g, ENTRIES - 1);

      // reserved channel
      stray_idx = -1;
      start_dump(3, 0, 0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check_eq("rsv_err",  err_cnt, 1);
      check_eq("rsv_eep",  eep_cnt, 0);
      check_eq("rsv_ram",  ram_cnt, 0);
      check_eq("rsv_busy", busy_cnt, 0);
      $display("[TB] reserved channel errs=%0d eep=%0d ram=%0d busy=%0d",
               err_cnt, eep_cnt, ram_cnt, busy_cnt);

      // randomized dumps
      for (int t = 0; t < 3; t++) begin
         ch = $urandom_range(0, 2); g = $urandom_range(0, 7);
         te = $urandom_range(0, ENTRIES - 1);
         hold_idx  = $urandom_range(0, ENTRIES - 1); hold_len = $urandom_range(5, 30);
         stray_idx = $urandom_range(0, ENTRIES - 1);
         start_dump(ch, g, te);
         wait_done();
         verify_dump($sformatf("rand%0d", t), ch, g, te);
      end

      // reset in the middle of a dump
      hold_idx = -1; stray_idx = -1;
      start_dump(2, 3, 100);
      for (int c = 0; c < 10000 && send_cnt < 200; c++) @(posedge clk);
      check_eq("mid_reached200", send_cnt, 200);
      @(posedge clk); #2 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("mid_busy",     int'(bus.busy), 0);
      check_eq("mid_ram_sel",  int'(bus.ram_sel), 0);
      check_eq("mid_ram_addr", int'(bus.ram_addr), 0);
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      check_eq("mid_no_done", done_cnt, 0);
      $display("[TB] reset mid-dump after %0d sends, dones=%0d", send_cnt, done_cnt);

      g = $urandom_range(0, 7); te = $urandom_range(0, ENTRIES - 1);
      start_dump(0, g, te);
      wait_done();
      verify_dump("after_rst", 0, g, te);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
